// File: rtl/keypad_emulator_pkg.sv
// Shared keypad definitions: key position map, emulator FSM states and timing defaults.
// The decoder imports the same KEY_MAP so digit-to-matrix placement has a single source.
package keypad_pkg;

    localparam int PRESS_CLKS_DEF    = 2500000;
    localparam int BOUNCE_CLKS_DEF   = 25000;
    localparam int BOUNCE_TOGGLE_DEF = 1250;
    localparam int GAP_CLKS_DEF      = 250000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BOUNCE_IN,
        ST_PRESSED,
        ST_BOUNCE_OUT,
        ST_GAP
    } kp_state_e;

    // digit -> {row[1:0], col[1:0]}; rows top to bottom: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D
    localparam logic [3:0] KEY_MAP [16] = '{
        4'hC, 4'h0, 4'h1, 4'h2,   // 0 1 2 3
        4'h4, 4'h5, 4'h6, 4'h8,   // 4 5 6 7
        4'h9, 4'hA, 4'h3, 4'h7,   // 8 9 A B
        4'hB, 4'hF, 4'hE, 4'hD    // C D E F
    };

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Down-counter reload value for an n-cycle interval.
    function automatic int ld(input int n);
        return (n > 0) ? n - 1 : 0;
    endfunction

endpackage

// File: rtl/keypad_emulator_if.sv
// Request handshake and matrix-scan signals between the decoder/test side and the emulator.
interface keypad_emulator_if;
    logic       i_Key_DV;
    logic [3:0] i_Key_Digit;
    logic       o_Ready;
    logic       o_Done;
    logic [3:0] i_Col;
    logic [3:0] o_Row;
    logic       o_Contact;

    modport master (output i_Key_DV, i_Key_Digit, i_Col,
                    input  o_Ready, o_Done, o_Row, o_Contact);
    modport slave  (input  i_Key_DV, i_Key_Digit, i_Col,
                    output o_Ready, o_Done, o_Row, o_Contact);
endinterface

// File: rtl/keypad_emulator_contact_timer.sv
// Contact timing FSM: bounce-in, solid press, bounce-out and open gap, one shared down-counter
// plus a toggle counter that only advances inside the bounce windows.
module keypad_contact_timer
    import keypad_pkg::*;
#(
    parameter int PRESS_CLKS    = PRESS_CLKS_DEF,
    parameter int BOUNCE_CLKS   = BOUNCE_CLKS_DEF,
    parameter int BOUNCE_TOGGLE = BOUNCE_TOGGLE_DEF,
    parameter int GAP_CLKS      = GAP_CLKS_DEF
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    output logic contact_o,
    output logic ready_o,
    output logic done_o
);
    localparam int CW = $clog2(max4(PRESS_CLKS, BOUNCE_CLKS, BOUNCE_TOGGLE, GAP_CLKS) + 1);
    localparam int TW = $clog2(BOUNCE_TOGGLE + 1);
    localparam logic [CW-1:0] PRESS_LD  = CW'(ld(PRESS_CLKS));
    localparam logic [CW-1:0] BOUNCE_LD = CW'(ld(BOUNCE_CLKS));
    localparam logic [CW-1:0] GAP_LD    = CW'(ld(GAP_CLKS));
    localparam logic [TW-1:0] TOG_LD    = TW'(ld(BOUNCE_TOGGLE));
    localparam bit            NO_BOUNCE = (BOUNCE_CLKS == 0);

    kp_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     tog_q, tog_d;
    logic              ph_q, ph_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tog_q   <= '0;
            ph_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tog_q   <= tog_d;
            ph_q    <= ph_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tog_d   = tog_q;
        ph_d    = ph_q;
        case (state_q)
            ST_IDLE: if (start_i) begin
                if (NO_BOUNCE) begin
                    state_d = ST_PRESSED;
                    cnt_d   = PRESS_LD;
                end else begin
                    state_d = ST_BOUNCE_IN;
                    cnt_d   = BOUNCE_LD;
                    tog_d   = TOG_LD;
                    ph_d    = 1'b1;
                end
            end
            ST_BOUNCE_IN, ST_BOUNCE_OUT: begin
                if (tog_q == '0) begin
                    tog_d = TOG_LD;
                    ph_d  = ~ph_q;
                end else begin
                    tog_d = tog_q - TW'(1);
                end
                if (cnt_q == '0) begin
                    state_d = (state_q == ST_BOUNCE_IN) ? ST_PRESSED : ST_GAP;
                    cnt_d   = (state_q == ST_BOUNCE_IN) ? PRESS_LD : GAP_LD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_PRESSED: if (cnt_q == '0) begin
                if (NO_BOUNCE) begin
                    state_d = ST_GAP;
                    cnt_d   = GAP_LD;
                end else begin
                    // release bounce starts from the open position
                    state_d = ST_BOUNCE_OUT;
                    cnt_d   = BOUNCE_LD;
                    tog_d   = TOG_LD;
                    ph_d    = 1'b0;
                end
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            ST_GAP: if (cnt_q == '0) begin
                state_d = ST_IDLE;
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o   = (state_q == ST_IDLE);
        done_o    = (state_q == ST_GAP) && (cnt_q == '0);
        contact_o = 1'b0;
        case (state_q)
            ST_BOUNCE_IN, ST_BOUNCE_OUT: contact_o = ph_q;
            ST_PRESSED:                  contact_o = 1'b1;
            default:                     contact_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/keypad_emulator.sv
// Keypad emulator top: key capture, reset synchronizer and the registered row response
// that answers the decoder's active-low column drive.
module keypad_emulator
    import keypad_pkg::*;
#(
    parameter int PRESS_CLKS    = PRESS_CLKS_DEF,
    parameter int BOUNCE_CLKS   = BOUNCE_CLKS_DEF,
    parameter int BOUNCE_TOGGLE = BOUNCE_TOGGLE_DEF,
    parameter int GAP_CLKS      = GAP_CLKS_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Rst_L,
    keypad_emulator_if.slave   kp
);
    logic [1:0] rst_sync_q;
    logic       rst_n;
    logic       contact, ready, done, start;
    logic [3:0] key_q, key_d;
    logic [3:0] row_q, row_d;

    // Assert asynchronously, release two clocks after i_Rst_L rises.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign start = kp.i_Key_DV & ready;
    assign key_d = start ? KEY_MAP[kp.i_Key_Digit] : key_q;

    keypad_contact_timer #(
        .PRESS_CLKS    (PRESS_CLKS),
        .BOUNCE_CLKS   (BOUNCE_CLKS),
        .BOUNCE_TOGGLE (BOUNCE_TOGGLE),
        .GAP_CLKS      (GAP_CLKS)
    ) u_timer (
        .clk_i     (i_Clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .contact_o (contact),
        .ready_o   (ready),
        .done_o    (done)
    );

    // Other low columns are don't-care: only the captured key's column matters.
    always_comb begin
        row_d = 4'b1111;
        if (contact && !kp.i_Col[key_q[1:0]]) row_d[key_q[3:2]] = 1'b0;
    end

    always_ff @(posedge i_Clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= '0;
            row_q <= 4'b1111;
        end else begin
            key_q <= key_d;
            row_q <= row_d;
        end
    end

    assign kp.o_Row     = row_q;
    assign kp.o_Ready   = ready;
    assign kp.o_Done    = done;
    assign kp.o_Contact = contact;

endmodule

// File: tb/tb_keypad_emulator.sv
// Bench for keypad_emulator: per-cycle scoreboard of contact/row/ready/done, plus a small
// column-scanning decoder model in the loop for the end-to-end key check.
module tb_keypad_emulator;
    localparam int P = 20, B = 6, T = 2, G = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    keypad_emulator_if kpa();
    keypad_emulator_if kpb();

    keypad_emulator #(.PRESS_CLKS(P), .BOUNCE_CLKS(B), .BOUNCE_TOGGLE(T), .GAP_CLKS(G))
        dut_a (.i_Clk(clk), .i_Rst_L(rst_n), .kp(kpa.slave));
    keypad_emulator #(.PRESS_CLKS(P), .BOUNCE_CLKS(0), .BOUNCE_TOGGLE(T), .GAP_CLKS(G))
        dut_b (.i_Clk(clk), .i_Rst_L(rst_n), .kp(kpb.slave));

    // digit -> {row, col}, written out from the keypad face layout
    localparam logic [3:0] MAP [16] = '{
        4'hC, 4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8,
        4'h9, 4'hA, 4'h3, 4'h7, 4'hB, 4'hF, 4'hE, 4'hD
    };

    typedef struct {
        int         cyc;
        logic       c;
        logic [3:0] row;
        logic       rdy;
        logic       dn;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   dec_q[$];
    exp_t ea, eb;

    int vectors = 0, miscompares = 0, cyc = 0;
    int mode_a = 1, mode_b = 1;
    logic [3:0] fix_a = 4'b1101;
    int done_a = 0, done_b = 0, hi_b = 0, dec_dv = 0, dec_quiet = 0, dk = 0, d0 = 0;
    bit dec_arm = 1'b1;
    logic [3:0] prev_col_a = 4'hF;
    logic [3:0] mrow;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [3:0] col_at(input int mode, input logic [3:0] fix, input int c);
        logic [3:0] one = 4'b0001;
        case (mode)
            0:       return fix;
            1:       return ~(one << (c % 4));
            default: return ~(one << ((c / 2) % 4));
        endcase
    endfunction

    // Contact value k cycles after the request cycle (k=0 is the DV cycle itself).
    function automatic logic ct_at(input int k, input int bb);
        int j = k - 1;
        if (k <= 0) return 1'b0;
        if (j < bb) return ((j / T) % 2) == 0;
        j -= bb;
        if (j < P) return 1'b1;
        j -= P;
        if (j < bb) return ((j / T) % 2) == 1;
        return 1'b0;
    endfunction

    task automatic push_txn(input int dut, input int digit, input int bb);
        int         len = 2 + 2 * bb + P + G;
        logic [3:0] pos = MAP[digit];
        for (int k = 0; k < len; k++) begin
            exp_t       e;
            logic [3:0] pc;
            logic [3:0] r;
            pc = col_at((dut == 0) ? mode_a : mode_b, fix_a, cyc + k - 1);
            r  = 4'b1111;
            if (ct_at(k - 1, bb) && pc[pos[1:0]] == 1'b0) r[pos[3:2]] = 1'b0;
            e.cyc = cyc + k;
            e.c   = ct_at(k, bb);
            e.row = r;
            e.rdy = (k == 0) || (k == len - 1);
            e.dn  = (k == len - 2);
            if (dut == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    task automatic push_idle(input int dut, input int n);
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.cyc = cyc + k; e.c = 1'b0; e.row = 4'b1111; e.rdy = 1'b1; e.dn = 1'b0;
            if (dut == 0) qa.push_back(e);
            else          qb.push_back(e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic req(input int dut, input int digit, input int bb, input bit push);
        if (dut == 0) begin kpa.i_Key_DV = 1'b1; kpa.i_Key_Digit = 4'(digit); end
        else          begin kpb.i_Key_DV = 1'b1; kpb.i_Key_Digit = 4'(digit); end
        if (push) push_txn(dut, digit, bb);
        tick(1);
        kpa.i_Key_DV = 1'b0;
        kpb.i_Key_DV = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        kpa.i_Col = col_at(mode_a, fix_a, cyc);
        kpb.i_Col = col_at(mode_b, 4'hF, cyc);
    end

    always @(negedge clk) begin
        if (qa.size() > 0 && qa[0].cyc == cyc) begin
            ea = qa.pop_front();
            chk("A.contact", 32'(kpa.o_Contact), 32'(ea.c));
            chk("A.row",     32'(kpa.o_Row),     32'(ea.row));
            chk("A.ready",   32'(kpa.o_Ready),   32'(ea.rdy));
            chk("A.done",    32'(kpa.o_Done),    32'(ea.dn));
        end
        if (qb.size() > 0 && qb[0].cyc == cyc) begin
            eb = qb.pop_front();
            chk("B.contact", 32'(kpb.o_Contact), 32'(eb.c));
            chk("B.row",     32'(kpb.o_Row),     32'(eb.row));
            chk("B.ready",   32'(kpb.o_Ready),   32'(eb.rdy));
            chk("B.done",    32'(kpb.o_Done),    32'(eb.dn));
        end
        if (kpa.o_Done === 1'b1) done_a++;
        if (kpb.o_Done === 1'b1) done_b++;
        if (kpb.o_Contact === 1'b1) hi_b++;
    end

    // Decoder model: emits one key event on first hit, re-arms after 16 quiet cycles.
    always @(negedge clk) begin
        if (mode_a == 2 && kpa.o_Row != 4'b1111) begin
            if (dec_arm) begin
                dk = -1;
                for (int i = 0; i < 16; i++) begin
                    mrow = MAP[i];
                    if (kpa.o_Row[mrow[3:2]] == 1'b0 && prev_col_a[mrow[1:0]] == 1'b0) dk = i;
                end
                dec_dv++;
                dec_arm = 1'b0;
                if (dec_q.size() > 0) chk("DEC.key", 32'(dk), 32'(dec_q.pop_front()));
                else                  chk("DEC.unexpected", 32'(dec_dv), 32'd0);
            end
            dec_quiet = 0;
        end else begin
            if (dec_quiet < 16) dec_quiet++;
            else                dec_arm = 1'b1;
        end
        prev_col_a = kpa.i_Col;
    end

    initial begin
        kpa.i_Key_DV = 1'b0; kpa.i_Key_Digit = 4'h0; kpa.i_Col = 4'hF;
        kpb.i_Key_DV = 1'b0; kpb.i_Key_Digit = 4'h0; kpb.i_Col = 4'hF;

        // 1: reset state, then idle under a full column scan
        tick(3);
        chk("RST.row",     32'(kpa.o_Row),     32'hF);
        chk("RST.contact", 32'(kpa.o_Contact), 32'd0);
        chk("RST.ready",   32'(kpa.o_Ready),   32'd1);
        chk("RST.done",    32'(kpa.o_Done),    32'd0);
        rst_n = 1'b1;
        tick(4);
        push_idle(0, 8);
        push_idle(1, 8);
        tick(10);

        // 2: digit 5 with col1 held low, bounce on both edges
        mode_a = 0; fix_a = 4'b1101;
        tick(3);
        req(0, 5, B, 1'b1);
        tick(42);
        chk("T2.done_count", 32'(done_a), 32'd1);

        // 4: second request mid-press is dropped
        req(0, 5, B, 1'b1);
        tick(9);
        req(0, 9, B, 1'b0);
        tick(34);
        chk("T4.done_count", 32'(done_a), 32'd2);

        // 3: digit D through the scanning decoder model
        mode_a = 2;
        tick(4);
        dec_q.push_back(13);
        req(0, 13, B, 1'b1);
        tick(70);
        chk("T3.dec_events",  32'(dec_dv), 32'd1);
        chk("T3.dec_pending", 32'(dec_q.size()), 32'd0);
        chk("T3.done_count",  32'(done_a), 32'd3);

        // 5: no-bounce instance, digit A under a full scan
        req(1, 10, 0, 1'b1);
        tick(32);
        chk("T5.contact_cycles", 32'(hi_b), 32'd20);
        chk("T5.done_count",     32'(done_b), 32'd1);

        // 6: reset during bounce-in
        mode_a = 0; fix_a = 4'b1101;
        tick(3);
        req(0, 5, B, 1'b1);
        tick(1);
        chk("T6.row_before", 32'(kpa.o_Row), 32'hD);
        d0 = done_a;
        rst_n = 1'b0;
        #1;
        chk("T6.row_async",     32'(kpa.o_Row),     32'hF);
        chk("T6.contact_async", 32'(kpa.o_Contact), 32'd0);
        qa.delete();
        tick(3);
        rst_n = 1'b1;
        tick(4);
        push_idle(0, 5);
        tick(8);
        chk("T6.no_done", 32'(done_a), 32'(d0));

        chk("END.qa_drain", 32'(qa.size()), 32'd0);
        chk("END.qb_drain", 32'(qb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
